alu_req_scheduler: RTL

- Shares the single combinational 8-bit ALU between two requesters, for example the execute stage and the address/loop unit.
- Arbitrates round-robin and latches the winning operation.
- Holds the ALU select and operands stable for a programmable number of cycles, then captures the result and flags into a response register with a valid/ready handshake.
- Maintains the architectural flags register.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/rr_arb2.sv | 16 +
 rtl/alu_req_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, flag indices,
// opcode legality and the scheduler state encoding.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_FLAG_W = 7;
    localparam int unsigned ALU_SEL_W  = 8;

    localparam logic [ALU_SEL_W-1:0] OP_ADD  = 8'h01;
    localparam logic [ALU_SEL_W-1:0] OP_SUB  = 8'h02;
    localparam logic [ALU_SEL_W-1:0] OP_MUL  = 8'h03;
    localparam logic [ALU_SEL_W-1:0] OP_DIV  = 8'h04;
    localparam logic [ALU_SEL_W-1:0] OP_INC  = 8'h05;
    localparam logic [ALU_SEL_W-1:0] OP_DEC  = 8'h06;
    localparam logic [ALU_SEL_W-1:0] OP_MOD  = 8'h07;
    localparam logic [ALU_SEL_W-1:0] OP_SHL  = 8'h08;
    localparam logic [ALU_SEL_W-1:0] OP_SHR  = 8'h09;
    localparam logic [ALU_SEL_W-1:0] OP_AND  = 8'h0A;
    localparam logic [ALU_SEL_W-1:0] OP_NAND = 8'h0B;
    localparam logic [ALU_SEL_W-1:0] OP_NOR  = 8'h0D;
    localparam logic [ALU_SEL_W-1:0] OP_NOT  = 8'h0E;
    localparam logic [ALU_SEL_W-1:0] OP_OR   = 8'h0F;
    localparam logic [ALU_SEL_W-1:0] OP_XNOR = 8'h10;
    localparam logic [ALU_SEL_W-1:0] OP_XOR  = 8'h11;

    localparam int unsigned FLG_ZERO   = 0;
    localparam int unsigned FLG_CARRY  = 1;
    localparam int unsigned FLG_SIGN   = 2;
    localparam int unsigned FLG_PARITY = 3;
    localparam int unsigned FLG_INT    = 4;
    localparam int unsigned FLG_DIR    = 5;
    localparam int unsigned FLG_OVF    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // 0x0C is a hole in the opcode map; 0x00 and everything above 0x11 are unused.
    function automatic logic is_legal_op(input logic [ALU_SEL_W-1:0] op);
        return ((op >= OP_ADD) && (op <= OP_NAND)) || ((op >= OP_NOR) && (op <= OP_XOR));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, on contention
// the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = valid;
        if (valid == 2'b11) begin
            grant_c = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between two requesters: arbitrates, holds the ALU
// inputs for EXEC_CYCLES cycles, returns result/flags and owns the flags register.
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = ALU_DATA_W,
    parameter int unsigned FLAG_W      = ALU_FLAG_W,
    parameter int unsigned SEL_W       = ALU_SEL_W,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] flags_q
);

    localparam int unsigned      CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic [1:0]        grant_c;
    logic              pick_c;
    logic [SEL_W-1:0]  pick_op_c;
    logic [DATA_W-1:0] pick_a_c;
    logic [DATA_W-1:0] pick_b_c;
    logic              pick_err_c;
    logic              fire_c;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant_c    (grant_c)
    );

    // Ready is only offered while idle; gated by reset so nothing looks accepted during it.
    assign fire_c     = !reset && (state == IDLE) && (grant_c != 2'b00);
    assign req0_ready = fire_c && grant_c[0];
    assign req1_ready = fire_c && grant_c[1];

    assign pick_c    = grant_c[1];
    assign pick_op_c = pick_c ? req1_op : req0_op;
    assign pick_a_c  = pick_c ? req1_a  : req0_a;
    assign pick_b_c  = pick_c ? req1_b  : req0_b;

    // Illegal opcodes and division by zero never reach the ALU.
    assign pick_err_c = !is_legal_op(ALU_SEL_W'(pick_op_c))
                     || (((pick_op_c == SEL_W'(OP_DIV)) || (pick_op_c == SEL_W'(OP_MOD)))
                         && (pick_b_c == '0));

    // rsp_ready belongs to the requester named by rsp_id; it arrives here already routed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            rsp_err      <= 1'b0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_sel      <= '0;
            flags_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_c) begin
                        last_grant <= pick_c;
                        rsp_id     <= pick_c;
                        if (pick_err_c) begin
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_flags  <= '0;
                            state      <= RESP;
                        end else begin
                            alu_sel      <= pick_op_c;
                            alu_operand1 <= pick_a_c;
                            alu_operand2 <= pick_b_c;
                            cnt          <= '0;
                            state        <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        rsp_result   <= alu_result;
                        rsp_flags    <= alu_flags;
                        rsp_err      <= 1'b0;
                        rsp_valid    <= 1'b1;
                        alu_sel      <= '0;
                        alu_operand1 <= '0;
                        alu_operand2 <= '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!rsp_err) begin
                            flags_q <= rsp_flags;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
